// File: rtl/aes_pkg.sv
// Shared constants, engine state encoding and word-slot helper for the AES
// stream controller.
//   AES_BLK_W  : cipher block width (128)
//   AES_WORD_W : stream word width (32)
//   AES_WORDS  : words per block (4)
//   aes_state_e: engine FSM states IDLE / LOAD / WAIT
//   blk_word() : extract 32-bit slot (3 = bits [127:96]) of a block
package aes_pkg;

  localparam int unsigned AES_BLK_W  = 128;
  localparam int unsigned AES_WORD_W = 32;
  localparam int unsigned AES_WORDS  = 4;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    WAIT
  } aes_state_e;

  // Slot 3 is the most significant word, i.e. the first word on the stream.
  function automatic logic [AES_WORD_W-1:0] blk_word(input logic [AES_BLK_W-1:0] blk,
                                                     input logic [1:0]           slot);
    return blk[{slot, 5'd0} +: AES_WORD_W];
  endfunction

endpackage

// File: rtl/aes_blk_serializer.sv
// 128-to-32 output buffer. A load captures a whole block and raises m_valid;
// words are then presented most-significant first, one per valid/ready
// handshake. The fourth handshake drops m_valid.
// Ports:
//   clk, rst        : clock, synchronous active-low reset
//   load, blk       : capture blk into the buffer (only issued while m_valid=0)
//   m_data, m_valid : current output word and its valid flag
//   m_ready         : downstream accepts the word when m_valid & m_ready
module aes_blk_serializer
  import aes_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [AES_BLK_W-1:0]  blk,
  input  logic                  m_ready,
  output logic [AES_WORD_W-1:0] m_data,
  output logic                  m_valid
);

  logic [AES_BLK_W-1:0] out_buf;
  logic [1:0]           out_idx;

  always_ff @(posedge clk) begin
    if (!rst) begin
      out_buf <= '0;
      out_idx <= '0;
      m_valid <= 1'b0;
    end else if (load) begin
      out_buf <= blk;
      out_idx <= '0;
      m_valid <= 1'b1;
    end else if (m_valid && m_ready) begin
      out_idx <= out_idx + 2'd1;
      if (out_idx == 2'(AES_WORDS - 1)) m_valid <= 1'b0;
    end
  end

  assign m_data = blk_word(out_buf, 2'd3 - out_idx);

endmodule

// File: rtl/aes_stream_ctrl.sv
// Stream front/back end for the iterative AES-128 core. Packs four 32-bit
// input words into a block, launches the core with a one-cycle core_ld,
// captures core_text_out on core_done and serializes it back out as words.
// Only one block is ever in flight; the next block may fill during WAIT.
// Build option: define AES_STREAM_CBC_EN for CBC chaining (core input is
// block XOR chain register; chain loads from iv_in and from every ciphertext).
// Without it the design is ECB and iv_we/iv_in are ignored.
// Ports:
//   clk, rst              : clock, synchronous active-low reset
//   key_we, key_in        : key register write (dropped while busy)
//   iv_we, iv_in          : chain register write (CBC build, dropped while busy)
//   s_data/s_valid/s_ready: input word stream, first word = block [127:96]
//   m_data/m_valid/m_ready: output word stream, first word = ciphertext [127:96]
//   busy                  : engine active, block pending, or output pending
//   core_ld, core_key, core_text_in : core launch interface (registered)
//   core_done, core_text_out        : core completion interface
module aes_stream_ctrl
  import aes_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  key_we,
  input  logic [AES_BLK_W-1:0]  key_in,
  input  logic                  iv_we,
  input  logic [AES_BLK_W-1:0]  iv_in,
  input  logic [AES_WORD_W-1:0] s_data,
  input  logic                  s_valid,
  output logic                  s_ready,
  output logic [AES_WORD_W-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  busy,
  output logic                  core_ld,
  output logic [AES_BLK_W-1:0]  core_key,
  output logic [AES_BLK_W-1:0]  core_text_in,
  input  logic                  core_done,
  input  logic [AES_BLK_W-1:0]  core_text_out
);

  aes_state_e           state;
  logic [1:0]           in_idx;
  logic                 in_full;
  logic [AES_BLK_W-1:0] in_buf;
  logic [AES_BLK_W-1:0] launch_text;
  logic                 out_valid;
  logic                 capture;

  assign s_ready = !in_full;
  assign capture = (state == WAIT) && core_done;
  assign busy    = (state != IDLE) || in_full || out_valid;
  assign m_valid = out_valid;

  // Packer and engine share in_full (packer sets it, LOAD clears it), so both
  // live in one block. s_ready=0 in LOAD, so the two never collide.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= IDLE;
      in_idx       <= '0;
      in_full      <= 1'b0;
      in_buf       <= '0;
      core_ld      <= 1'b0;
      core_text_in <= '0;
    end else begin
      core_ld <= 1'b0;
      if (s_valid && s_ready) begin
        in_buf[{2'd3 - in_idx, 5'd0} +: AES_WORD_W] <= s_data;
        in_idx <= in_idx + 2'd1;
        if (in_idx == 2'(AES_WORDS - 1)) in_full <= 1'b1;
      end
      case (state)
        IDLE: begin
          // Wait for the previous ciphertext to drain before launching.
          if (in_full && !out_valid) begin
            state        <= LOAD;
            core_ld      <= 1'b1;
            core_text_in <= launch_text;
          end
        end
        LOAD: begin
          in_full <= 1'b0;
          state   <= WAIT;
        end
        WAIT: begin
          if (core_done) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      core_key <= '0;
    end else if (key_we && !busy) begin
      core_key <= key_in;
    end
  end

`ifdef AES_STREAM_CBC_EN
  logic [AES_BLK_W-1:0] chain;

  // Capture only happens in WAIT (busy=1), so it never races an IV write.
  always_ff @(posedge clk) begin
    if (!rst) begin
      chain <= '0;
    end else if (capture) begin
      chain <= core_text_out;
    end else if (iv_we && !busy) begin
      chain <= iv_in;
    end
  end

  assign launch_text = in_buf ^ chain;
`else
  logic unused_iv;
  assign unused_iv   = ^{iv_we, iv_in};
  assign launch_text = in_buf;
`endif

  aes_blk_serializer u_ser (
    .clk     (clk),
    .rst     (rst),
    .load    (capture),
    .blk     (core_text_out),
    .m_ready (m_ready),
    .m_data  (m_data),
    .m_valid (out_valid)
  );

endmodule
